aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl.sv | 100 ++++++++++
 tb/tb_aes_round_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES round sequencer for key expansion, initial AddRoundKey, Nr-1 full rounds and a final round,
// with a result handshake, an abort path and a key-expansion timeout.
module aes_round_ctrl #(
  parameter int KEXP_TO = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic       fwd_ninv_i,
  input  logic [1:0] key_len_i,
  input  logic       new_key_i,
  output logic       kexp_start_o,
  input  logic       kexp_done_i,
  output logic       load_o,
  output logic       dp_en_o,
  output logic       mix_en_o,
  output logic [3:0] rk_idx_o,
  output logic       fwd_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  input  logic       abort_i,
  output logic       busy_o,
  output logic       err_o
);
  typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL, DONE} state_t;
  state_t      r_state;
  logic [3:0]  r_nr;
  logic [3:0]  r_rk;
  logic [7:0]  r_cnt;
  logic        r_fwd;
  logic        r_err;
  logic        w_accept;
  logic [3:0]  w_nr;
  assign w_nr     = key_len_i == 2'b00 ? 4'd10 : key_len_i == 2'b01 ? 4'd12 : 4'd14;
  assign w_accept = in_valid_i & in_ready_o;
  // r_cnt == 1 marks the first KEXP cycle: start pulses there and done is ignored
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_nr    <= 4'd0;
      r_rk    <= 4'd0;
      r_cnt   <= 8'd0;
      r_fwd   <= 1'b0;
      r_err   <= 1'b0;
    end else if (abort_i) begin
      r_state <= IDLE;
      r_rk    <= 4'd0;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_fwd   <= fwd_ninv_i;
          r_nr    <= w_nr;
          r_err   <= &key_len_i;
          r_state <= new_key_i ? KEXP : INIT;
          r_rk    <= (new_key_i | fwd_ninv_i) ? 4'd0 : w_nr;
          r_cnt   <= new_key_i ? 8'd1 : 8'd0;
        end
        KEXP: if (r_cnt != 8'd1 && kexp_done_i) begin
          r_state <= INIT;
          r_rk    <= r_fwd ? 4'd0 : r_nr;
          r_cnt   <= 8'd0;
        end else if (r_cnt == 8'(KEXP_TO)) begin
          r_state <= IDLE;
          r_err   <= 1'b1;
          r_cnt   <= 8'd0;
        end else begin
          r_cnt   <= r_cnt + 8'd1;
        end
        INIT: begin
          r_state <= ROUND;
          r_rk    <= r_fwd ? 4'd1 : r_nr - 4'd1;
        end
        ROUND: if (r_rk == (r_fwd ? r_nr - 4'd1 : 4'd1)) begin
          r_state <= FINAL;
          r_rk    <= r_fwd ? r_nr : 4'd0;
        end else begin
          r_rk    <= r_fwd ? r_rk + 4'd1 : r_rk - 4'd1;
        end
        FINAL: begin
          r_state <= DONE;
          r_rk    <= 4'd0;
        end
        DONE: if (out_ready_i) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign in_ready_o   = (r_state == IDLE) & rst_i & ~abort_i;
  assign kexp_start_o = (r_state == KEXP) & (r_cnt == 8'd1);
  assign load_o       = r_state == INIT;
  assign dp_en_o      = (r_state == ROUND) | (r_state == FINAL);
  assign mix_en_o     = r_state == ROUND;
  assign out_valid_o  = r_state == DONE;
  assign busy_o       = r_state != IDLE;
  assign rk_idx_o     = r_rk;
  assign fwd_o        = r_fwd;
  assign err_o        = r_err;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: table-driven and randomized checks of the AES round sequencer against a per-cycle model.
module tb_aes_round_ctrl;
  localparam int TO = 64;
  localparam int P_KEXP = 1, P_INIT = 2, P_ROUND = 3, P_FINAL = 4, P_DONE = 5;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, fwd_ninv = 1'b0, new_key = 1'b0;
  logic kdone = 1'b0, ordy = 1'b0, abort = 1'b0;
  logic [1:0] key_len = 2'd0;
  logic in_ready, kstart, load, dp, mix, fwd, oval, busy, err;
  logic [3:0] rk;
  int n_chk = 0, n_fail = 0;

  aes_round_ctrl #(.KEXP_TO(TO)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .fwd_ninv_i(fwd_ninv), .key_len_i(key_len), .new_key_i(new_key),
    .kexp_start_o(kstart), .kexp_done_i(kdone), .load_o(load), .dp_en_o(dp),
    .mix_en_o(mix), .rk_idx_o(rk), .fwd_o(fwd), .out_valid_o(oval),
    .out_ready_i(ordy), .abort_i(abort), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {int ph; int j; logic [11:0] v;} cyc_t;
  typedef struct {logic f; logic [1:0] kl; logic nk; int kd; int rd; int stop; int kind; logic e_err; int e_lat;} vec_t;
  cyc_t exp_q[$];
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] pack(input logic ir, input logic bz, input logic ov, input logic st,
                                        input logic ld, input logic d, input logic m, input logic [3:0] r,
                                        input logic f);
    return {ir, bz, ov, st, ld, d, m, r, f};
  endfunction

  function automatic logic [11:0] obs();
    return {in_ready, busy, oval, kstart, load, dp, mix, rk, fwd};
  endfunction

  function automatic int nr_of(input logic [1:0] kl);
    return kl == 2'd0 ? 10 : kl == 2'd1 ? 12 : 14;
  endfunction

  // expected outputs for every cycle after accept, from the round schedule itself
  function automatic void build(input logic f, input logic [1:0] kl, input logic nk, input int kd, input int rd);
    int nr = nr_of(kl);
    exp_q.delete();
    if (nk) begin
      for (int j = 1; j <= (kd == 0 ? TO : kd); j++)
        exp_q.push_back('{P_KEXP, j, pack(0, 1, 0, j == 1, 0, 0, 0, 4'd0, f)});
      if (kd == 0) return;
    end
    exp_q.push_back('{P_INIT, 0, pack(0, 1, 0, 0, 1, 0, 0, f ? 4'd0 : 4'(nr), f)});
    for (int i = 1; i < nr; i++)
      exp_q.push_back('{P_ROUND, i, pack(0, 1, 0, 0, 0, 1, 1, 4'(f ? i : nr - i), f)});
    exp_q.push_back('{P_FINAL, 0, pack(0, 1, 0, 0, 0, 1, 0, f ? 4'(nr) : 4'd0, f)});
    for (int j = 0; j <= rd; j++)
      exp_q.push_back('{P_DONE, j, pack(0, 1, 1, 0, 0, 0, 0, 4'd0, f)});
  endfunction

  task automatic run(input logic f, input logic [1:0] kl, input logic nk, input int kd, input int rd,
                     input int stop_at, input int kind, output int first_ov);
    int w = 0;
    first_ov = 0;
    build(f, kl, nk, kd, rd);
    @(negedge clk);
    while (!in_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("accept_wait", {31'd0, in_ready}, 32'd1);
      return;
    end
    in_valid = 1'b1; fwd_ninv = f; key_len = kl; new_key = nk; kdone = 1'b0; ordy = 1'($urandom);
    foreach (exp_q[c]) begin
      @(negedge clk);
      in_valid = 1'b0;
      fwd_ninv = 1'($urandom); key_len = 2'($urandom); new_key = 1'($urandom);
      if (oval && first_ov == 0) first_ov = c + 1;
      chk($sformatf("cyc%0d", c + 1), {20'd0, obs()}, {20'd0, exp_q[c].v});
      if (c + 1 == stop_at) begin
        if (kind == 1) begin
          abort = 1'b1;
          @(negedge clk);
          chk("abort_idle", {20'd0, obs()}, {20'd0, pack(0, 0, 0, 0, 0, 0, 0, 4'd0, f)});
          chk("abort_err", {31'd0, err}, {31'd0, kl == 2'd3});
          abort = 1'b0;
          #1 chk("abort_rdy", {31'd0, in_ready}, 32'd1);
        end else begin
          rst = 1'b0;
          #1 chk("rst_async", {19'd0, obs(), err}, 32'd0);
          @(negedge clk);
          rst = 1'b1;
          #1 chk("rst_rdy", {31'd0, in_ready}, 32'd1);
        end
        return;
      end
      kdone = exp_q[c].ph == P_KEXP && (exp_q[c].j == 1 || exp_q[c].j == kd);
      ordy = exp_q[c].ph == P_DONE ? exp_q[c].j >= rd : 1'($urandom);
    end
    @(negedge clk);
    chk("idle", {20'd0, obs()}, {20'd0, pack(1, 0, 0, 0, 0, 0, 0, 4'd0, f)});
    kdone = 1'b0;
    ordy = 1'b0;
  endtask

  initial begin
    int lat;
    tbl[0] = '{1'b1, 2'd0, 1'b0, 0, 0, 0, 0, 1'b0, 12};
    tbl[1] = '{1'b0, 2'd2, 1'b1, 5, 0, 0, 0, 1'b0, 21};
    tbl[2] = '{1'b1, 2'd3, 1'b0, 0, 1, 0, 0, 1'b1, 16};
    tbl[3] = '{1'b1, 2'd0, 1'b0, 0, 0, 0, 0, 1'b0, 12};
    tbl[4] = '{1'b0, 2'd1, 1'b1, 0, 0, 0, 0, 1'b1, 0};
    tbl[5] = '{1'b1, 2'd1, 1'b0, 0, 7, 0, 0, 1'b0, 14};
    tbl[6] = '{1'b0, 2'd0, 1'b1, 2, 2, 0, 0, 1'b0, 14};
    tbl[7] = '{1'b1, 2'd0, 1'b0, 0, 0, 6, 1, 1'b0, 0};
    tbl[8] = '{1'b1, 2'd0, 1'b0, 0, 0, 11, 2, 1'b0, 0};
    tbl[9] = '{1'b0, 2'd0, 1'b0, 0, 1, 0, 0, 1'b0, 12};
    #7 chk("reset_outs", {19'd0, obs(), err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_hold", {19'd0, obs(), err}, 32'd0);
    rst = 1'b1;
    #1 chk("reset_rel_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    abort = 1'b1;
    in_valid = 1'b1;
    #1 chk("abort_blocks_rdy", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("abort_no_accept", {31'd0, busy}, 32'd0);
    abort = 1'b0;
    in_valid = 1'b0;
    foreach (tbl[i]) begin
      run(tbl[i].f, tbl[i].kl, tbl[i].nk, tbl[i].kd, tbl[i].rd, tbl[i].stop, tbl[i].kind, lat);
      chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, tbl[i].e_err});
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].e_lat);
    end
    for (int n = 0; n < 25; n++) begin
      logic f, nk;
      logic [1:0] kl;
      int kd, rd;
      f = 1'($urandom); kl = 2'($urandom); nk = 1'($urandom);
      kd = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(2, 9);
      rd = $urandom_range(0, 3);
      run(f, kl, nk, kd, rd, 0, 0, lat);
      chk($sformatf("rnd%0d_err", n), {31'd0, err}, {31'd0, kl == 2'd3 || (nk && kd == 0)});
      chk($sformatf("rnd%0d_lat", n), lat, (nk && kd == 0) ? 0 : (nk ? kd : 0) + nr_of(kl) + 2);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
